axi4lite_mem_slave: RTL and testbench
=====================================

Name: axi4lite_mem_slave

Overview:
- Synthesizable, parametrised AXI4-Lite memory slave for the picorv32 AXI core in simulation and FPGA bring-up.
- Provides a word-addressed RAM with byte strobes and a configurable read latency.
- Two MMIO ports: a console byte sink and a test-pass flag.
- Out-of-range accesses return a DECERR response instead of halting simulation.
- Optional LFSR-driven stall injection stresses the master's handshakes.

Parameters:
MEM_WORDS, 16384, RAM depth in 32-bit words; must be a power of 2.
READ_LATENCY, 1, cycles from AR acceptance to rvalid; legal range 1..15.
CONSOLE_ADDR, 32'h1000_0000, write-only console byte address.
PASS_ADDR, 32'h2000_0000, test-pass register address.
PASS_VALUE, 32'd123456789, value that sets tests_passed.
LFSR_SEED, 16'hACE1, stall-LFSR reset value; must be nonzero.

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
mem_axi_awvalid/awready  in/out  1/1  write-address handshake
mem_axi_awaddr  in  32  write byte address
mem_axi_awprot  in  3  ignored
mem_axi_wvalid/wready  in/out  1/1  write-data handshake
mem_axi_wdata  in  32  write data
mem_axi_wstrb  in  4  byte-lane enables
mem_axi_bvalid/bready  out/in  1/1  write-response handshake
mem_axi_bresp  out  2  00 OKAY, 11 DECERR
mem_axi_arvalid/arready  in/out  1/1  read-address handshake
mem_axi_araddr  in  32  read byte address
mem_axi_arprot  in  3  ignored
mem_axi_rvalid/rready  out/in  1/1  read-data handshake
mem_axi_rdata  out  32  read data
mem_axi_rresp  out  2  00 OKAY, 11 DECERR
out_valid  out  1  one-cycle pulse per console write
out_data  out  8  console byte
tests_passed  out  1  sticky pass flag

Behaviour:
- Reset (resetn low, asynchronous):
  - All ready/valid outputs, bresp, rresp, rdata, out_valid, out_data and tests_passed go to 0.
  - AW, W and AR holding latches are cleared. In-flight transactions are dropped with no response after reset.
  - RAM contents are not reset.
- Address decode:
  - RAM hit when addr < 4*MEM_WORDS; word index = addr[..:2]; addr[1:0] ignored.
  - CONSOLE_ADDR and PASS_ADDR are exact 32-bit matches.
  - Any other address is a miss: response DECERR, no side effect, rdata = 0.
- Write channel:
  - AW and W each have a one-entry latch and are accepted independently in either order.
  - awready is 1 when the AW latch is empty, and is registered; wready likewise for the W latch.
  - A handshake occurs on a cycle where valid && ready; that latch fills and its ready drops the next cycle.
  - The commit cycle is the first cycle both latches are full and bvalid = 0. On that cycle:
    - RAM bytes are written per wstrb.
    - A console write raises out_valid for 1 cycle, with out_data = wdata[7:0].
    - A PASS_ADDR write with wdata == PASS_VALUE sets tests_passed; other values leave it unchanged.
  - bvalid and bresp are asserted the cycle after commit and hold until bready.
  - Both latches free on the B handshake, so ready reasserts the next cycle.
  - Max write throughput: one write per 3 cycles.
- Read channel:
  - arready is 1 when the AR latch is empty.
  - After the AR handshake, a counter loads READ_LATENCY-1. RAM is sampled when the counter reaches 0, and rvalid rises the following cycle.
  - With READ_LATENCY = 1, rvalid is asserted 1 cycle after the AR handshake.
  - rdata and rresp are stable while rvalid && !rready. The latch frees on the R handshake.
  - Only one read is outstanding at a time.
- Read/write collision: if a read samples RAM in the same cycle as a commit to the same word, the read returns the pre-write data.
- MMIO reads: the console address reads 0 with OKAY; the pass address reads {31'b0, tests_passed} with OKAY.
- Concurrency: the read and write channels are fully independent, with no ordering between them.

Optional Feature:
- Macro AXI_STALL_INJECT_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed LFSR_SEED) advances every cycle.
  - LFSR bits [4:0] respectively gate awready, wready, arready, the commit and the read-sample step. A gated step is delayed by that cycle only.
  - Valids are never withdrawn once asserted.
- When undefined: no LFSR is built and timing is exactly as stated above.

Test Plan:
- Reset, then AW 0x0000_0010 and W 0xDEADBEEF strb 4'b1111 presented together -> bvalid 2 cycles after the handshake, bresp=00. Then AR 0x10 -> rdata=0xDEADBEEF, rresp=00, rvalid 1 cycle after the AR handshake.
- Partial write strb 4'b0010 data 0x0000_5500 to the word holding 0xDEADBEEF -> readback 0xDEAD55EF.
- W sent 3 cycles before AW, with bready held low 5 cycles -> W accepted alone, single commit after AW arrives, bvalid held stable until bready, exactly one B handshake.
- Write 0x41 to 0x1000_0000 -> out_valid pulse of exactly 1 cycle, out_data=0x41. Write 123456789 to 0x2000_0000 -> tests_passed=1 and stays 1 after a later write of 0.
- AR 0x0001_0000 with MEM_WORDS=16384 -> rresp=11, rdata=0. Write to 0x3000_0000 -> bresp=11, RAM unchanged.
- READ_LATENCY=4 with resetn pulsed low 2 cycles after the AR handshake -> rvalid never asserts for that read, and arready=1 on the first cycle after reset release.

Source files
------------

// File: rtl/axi4lite_mem_slave_if.sv
// AXI4-Lite bus bundle between the picorv32 AXI master and axi4lite_mem_slave.
// Signal names match the original flat port list so existing hookups map one-to-one.
interface axi4lite_mem_slave_if;
  logic        mem_axi_awvalid;
  logic        mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid;
  logic        mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid;
  logic        mem_axi_bready;
  logic [1:0]  mem_axi_bresp;
  logic        mem_axi_arvalid;
  logic        mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid;
  logic        mem_axi_rready;
  logic [31:0] mem_axi_rdata;
  logic [1:0]  mem_axi_rresp;

  modport slave (
    input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    input  mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    input  mem_axi_bready,
    input  mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
    input  mem_axi_rready,
    output mem_axi_awready, mem_axi_wready,
    output mem_axi_bvalid, mem_axi_bresp,
    output mem_axi_arready,
    output mem_axi_rvalid, mem_axi_rdata, mem_axi_rresp
  );

  modport master (
    output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    output mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    output mem_axi_bready,
    output mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
    output mem_axi_rready,
    input  mem_axi_awready, mem_axi_wready,
    input  mem_axi_bvalid, mem_axi_bresp,
    input  mem_axi_arready,
    input  mem_axi_rvalid, mem_axi_rdata, mem_axi_rresp
  );
endinterface

// File: rtl/axi4lite_mem_slave.sv
// AXI4-Lite RAM slave with console/pass MMIO, DECERR on unmapped addresses, and read latency.
// Define AXI_STALL_INJECT_EN to build an LFSR that randomly gates readies, commit and read sampling.
module axi4lite_mem_slave #(
  parameter int unsigned MEM_WORDS    = 16384,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
  parameter logic [31:0] PASS_VALUE   = 32'd123456789,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       resetn,
  axi4lite_mem_slave_if.slave        bus,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  output logic                       tests_passed
);

  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  LAT_LOAD  = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    REG_RAM,
    REG_CONSOLE,
    REG_PASS,
    REG_MISS
  } region_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_RESP
  } rd_state_e;

  function automatic region_e decode(input logic [31:0] addr);
    if ({1'b0, addr} < RAM_BYTES) return REG_RAM;
    if (addr == CONSOLE_ADDR)     return REG_CONSOLE;
    if (addr == PASS_ADDR)        return REG_PASS;
    return REG_MISS;
  endfunction

  logic [31:0] mem_q [MEM_WORDS];

  // ---------------------------------------------------------------------------
  // Stall gates: *_gate_d steers next-cycle readies, the others gate this cycle.
  // ---------------------------------------------------------------------------
  logic [2:0] rdy_gate_d;
  logic       commit_gate;
  logic       sample_gate;

`ifdef AXI_STALL_INJECT_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign rdy_gate_d  = lfsr_d[2:0];
  assign commit_gate = lfsr_q[3];
  assign sample_gate = lfsr_q[4];
`else
  assign rdy_gate_d  = '1;
  assign commit_gate = 1'b1;
  assign sample_gate = 1'b1;
`endif

  logic unused_prot;
  assign unused_prot = ^{bus.mem_axi_awprot, bus.mem_axi_arprot};

  // ---------------------------------------------------------------------------
  // Write channel: independent AW/W latches, single commit, held B response.
  // ---------------------------------------------------------------------------
  logic        awready_q, wready_q;
  logic        aw_full_q, w_full_q;
  logic [31:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        out_valid_q;
  logic [7:0]  out_data_q;
  logic        passed_q;

  logic        aw_hs, w_hs, b_hs, commit;
  logic        aw_full_d, w_full_d, awready_d, wready_d;
  region_e     wr_region;

  assign aw_hs     = bus.mem_axi_awvalid && awready_q;
  assign w_hs      = bus.mem_axi_wvalid && wready_q;
  assign b_hs      = bvalid_q && bus.mem_axi_bready;
  // bvalid rises right after commit, so "both full && !bvalid" is true for one cycle only.
  assign commit    = aw_full_q && w_full_q && !bvalid_q && commit_gate;
  assign wr_region = decode(aw_addr_q);

  assign aw_full_d = b_hs ? 1'b0 : (aw_full_q || aw_hs);
  assign w_full_d  = b_hs ? 1'b0 : (w_full_q || w_hs);
  assign awready_d = !aw_full_d && rdy_gate_d[0];
  assign wready_d  = !w_full_d && rdy_gate_d[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      aw_full_q   <= 1'b0;
      w_full_q    <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      passed_q    <= 1'b0;
    end else begin
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      aw_full_q   <= aw_full_d;
      w_full_q    <= w_full_d;
      out_valid_q <= 1'b0;
      if (aw_hs) aw_addr_q <= bus.mem_axi_awaddr;
      if (w_hs) begin
        w_data_q <= bus.mem_axi_wdata;
        w_strb_q <= bus.mem_axi_wstrb;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (wr_region == REG_MISS) ? 2'b11 : 2'b00;
        if (wr_region == REG_CONSOLE) begin
          out_valid_q <= 1'b1;
          out_data_q  <= w_data_q[7:0];
        end
        if (wr_region == REG_PASS && w_data_q == PASS_VALUE) passed_q <= 1'b1;
      end else if (b_hs) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && wr_region == REG_RAM) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_strb_q[i]) mem_q[aw_addr_q[IDX_W+1:2]][8*i +: 8] <= w_data_q[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel: one outstanding read, countdown to the RAM sample.
  // ---------------------------------------------------------------------------
  rd_state_e   rd_state_q;
  logic        arready_q;
  logic [31:0] ar_addr_q;
  logic [3:0]  cnt_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic        ar_hs, rd_sample, arready_d;
  logic [31:0] rd_addr;
  region_e     rd_region;
  logic [31:0] rd_data_d;
  logic [1:0]  rd_resp_d;

  assign ar_hs = bus.mem_axi_arvalid && arready_q;

  // With READ_LATENCY==1 the sample happens on the AR handshake edge itself, straight off araddr.
  assign rd_sample = sample_gate &&
                     ((rd_state_q == RD_IDLE && ar_hs && READ_LATENCY == 1) ||
                      (rd_state_q == RD_WAIT && cnt_q <= 4'd1));

  assign arready_d = rdy_gate_d[2] &&
                     ((rd_state_q == RD_IDLE && !ar_hs) ||
                      (rd_state_q == RD_RESP && bus.mem_axi_rready));

  always_comb begin
    rd_addr   = (rd_state_q == RD_IDLE) ? bus.mem_axi_araddr : ar_addr_q;
    rd_region = decode(rd_addr);
    rd_data_d = '0;
    rd_resp_d = 2'b00;
    case (rd_region)
      REG_RAM:  rd_data_d = mem_q[rd_addr[IDX_W+1:2]];
      REG_PASS: rd_data_d = {31'b0, passed_q};
      REG_MISS: rd_resp_d = 2'b11;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      ar_addr_q  <= '0;
      cnt_q      <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
    end else begin
      arready_q <= arready_d;
      case (rd_state_q)
        RD_IDLE: begin
          if (ar_hs) begin
            ar_addr_q <= bus.mem_axi_araddr;
            cnt_q     <= LAT_LOAD;
            if (rd_sample) begin
              rvalid_q   <= 1'b1;
              rdata_q    <= rd_data_d;
              rresp_q    <= rd_resp_d;
              rd_state_q <= RD_RESP;
            end else begin
              rd_state_q <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (rd_sample) begin
            cnt_q      <= '0;
            rvalid_q   <= 1'b1;
            rdata_q    <= rd_data_d;
            rresp_q    <= rd_resp_d;
            rd_state_q <= RD_RESP;
          end else if (cnt_q > 4'd1) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RD_RESP: begin
          if (bus.mem_axi_rready) begin
            rvalid_q   <= 1'b0;
            rd_state_q <= RD_IDLE;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  assign bus.mem_axi_awready = awready_q;
  assign bus.mem_axi_wready  = wready_q;
  assign bus.mem_axi_bvalid  = bvalid_q;
  assign bus.mem_axi_bresp   = bresp_q;
  assign bus.mem_axi_arready = arready_q;
  assign bus.mem_axi_rvalid  = rvalid_q;
  assign bus.mem_axi_rdata   = rdata_q;
  assign bus.mem_axi_rresp   = rresp_q;
  assign out_valid           = out_valid_q;
  assign out_data            = out_data_q;
  assign tests_passed        = passed_q;

endmodule

// File: tb/tb_axi4lite_mem_slave.sv
// Directed bench for axi4lite_mem_slave: default instance plus a READ_LATENCY=4 instance.
module tb_axi4lite_mem_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst4_n = 1'b0;

  axi4lite_mem_slave_if bus();
  axi4lite_mem_slave_if bus4();

  logic       out_valid, out_valid4;
  logic [7:0] out_data, out_data4;
  logic       tests_passed, tests_passed4;

  int n_pass = 0;
  int n_total = 0;
  int ov_count = 0;
  logic [7:0] ov_last = '0;

  axi4lite_mem_slave #(
    .MEM_WORDS(16384),
    .READ_LATENCY(1)
  ) dut (
    .clk(clk),
    .resetn(rst_n),
    .bus(bus.slave),
    .out_valid(out_valid),
    .out_data(out_data),
    .tests_passed(tests_passed)
  );

  axi4lite_mem_slave #(
    .MEM_WORDS(16384),
    .READ_LATENCY(4)
  ) dut4 (
    .clk(clk),
    .resetn(rst4_n),
    .bus(bus4.slave),
    .out_valid(out_valid4),
    .out_data(out_data4),
    .tests_passed(tests_passed4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      ov_count++;
      ov_last = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_bus();
    bus.mem_axi_awvalid = 0; bus.mem_axi_awaddr = '0; bus.mem_axi_awprot = '0;
    bus.mem_axi_wvalid = 0; bus.mem_axi_wdata = '0; bus.mem_axi_wstrb = '0;
    bus.mem_axi_bready = 0; bus.mem_axi_arvalid = 0; bus.mem_axi_araddr = '0;
    bus.mem_axi_arprot = '0; bus.mem_axi_rready = 0;
    bus4.mem_axi_awvalid = 0; bus4.mem_axi_awaddr = '0; bus4.mem_axi_awprot = '0;
    bus4.mem_axi_wvalid = 0; bus4.mem_axi_wdata = '0; bus4.mem_axi_wstrb = '0;
    bus4.mem_axi_bready = 0; bus4.mem_axi_arvalid = 0; bus4.mem_axi_araddr = '0;
    bus4.mem_axi_arprot = '0; bus4.mem_axi_rready = 0;
  endtask

  // AW and W presented together; lat = cycles from the later handshake to bvalid.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat, output bit ok);
    bit aw_done, w_done, aw_f, w_f;
    int hs_t;
    ok = 0; lat = -1; resp = 'x; aw_done = 0; w_done = 0; hs_t = 0;
    bus.mem_axi_awaddr = a; bus.mem_axi_awvalid = 1;
    bus.mem_axi_wdata = d; bus.mem_axi_wstrb = s; bus.mem_axi_wvalid = 1;
    bus.mem_axi_bready = 1;
    for (int t = 0; t < 60 && !ok; t++) begin
      aw_f = 0; w_f = 0;
      if (aw_done && w_done && bus.mem_axi_bvalid) begin
        resp = bus.mem_axi_bresp; lat = t - hs_t; ok = 1;
      end else begin
        aw_f = !aw_done && bus.mem_axi_awvalid && bus.mem_axi_awready;
        w_f  = !w_done && bus.mem_axi_wvalid && bus.mem_axi_wready;
      end
      step();
      if (aw_f) begin bus.mem_axi_awvalid = 0; aw_done = 1; end
      if (w_f) begin bus.mem_axi_wvalid = 0; w_done = 1; end
      if ((aw_f || w_f) && aw_done && w_done) hs_t = t;
    end
    bus.mem_axi_awvalid = 0; bus.mem_axi_wvalid = 0; bus.mem_axi_bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] data,
                          output logic [1:0] resp, output int lat, output bit ok);
    bit ar_done, ar_f;
    int hs_t;
    ok = 0; lat = -1; data = 'x; resp = 'x; ar_done = 0; hs_t = 0;
    bus.mem_axi_araddr = a; bus.mem_axi_arvalid = 1; bus.mem_axi_rready = 1;
    for (int t = 0; t < 60 && !ok; t++) begin
      ar_f = 0;
      if (ar_done && bus.mem_axi_rvalid) begin
        data = bus.mem_axi_rdata; resp = bus.mem_axi_rresp; lat = t - hs_t; ok = 1;
      end else if (!ar_done) begin
        ar_f = bus.mem_axi_arvalid && bus.mem_axi_arready;
      end
      step();
      if (ar_f) begin bus.mem_axi_arvalid = 0; ar_done = 1; hs_t = t; end
    end
    bus.mem_axi_arvalid = 0; bus.mem_axi_rready = 0;
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    repeat (3) step();
    flags = {bus.mem_axi_awready, bus.mem_axi_wready, bus.mem_axi_arready, bus.mem_axi_bvalid,
             bus.mem_axi_rvalid, out_valid, tests_passed};
    n_total++;
    if (flags !== 7'b0) $display("FAIL reset_flags got=%b exp=0000000", flags); else n_pass++;
    n_total++;
    if ({bus.mem_axi_bresp, bus.mem_axi_rresp, bus.mem_axi_rdata, out_data} !== 44'h0)
      $display("FAIL reset_data bresp=%b rresp=%b rdata=%h out_data=%h exp=0",
               bus.mem_axi_bresp, bus.mem_axi_rresp, bus.mem_axi_rdata, out_data);
    else n_pass++;
    rst_n = 1; rst4_n = 1;
    step();
    n_total++;
    if ({bus.mem_axi_awready, bus.mem_axi_wready, bus.mem_axi_arready} !== 3'b111)
      $display("FAIL reset_release_ready got=%b exp=111",
               {bus.mem_axi_awready, bus.mem_axi_wready, bus.mem_axi_arready});
    else n_pass++;
  endtask

  task automatic test_basic_rw();
    logic [1:0] r; logic [31:0] d; int lat; bit ok;
    axi_write(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, r, lat, ok);
    n_total++;
    if (!ok || r !== 2'b00 || lat != 2)
      $display("FAIL basic_write ok=%0b bresp=%b lat=%0d exp ok=1 bresp=00 lat=2", ok, r, lat);
    else n_pass++;
    axi_read(32'h0000_0010, d, r, lat, ok);
    n_total++;
    if (!ok || lat != 1)
      $display("FAIL basic_read_latency ok=%0b lat=%0d exp ok=1 lat=1", ok, lat);
    else n_pass++;
    n_total++;
    if (d !== 32'hDEAD_BEEF || r !== 2'b00)
      $display("FAIL basic_read_data got=%h/%b exp=deadbeef/00", d, r);
    else n_pass++;
  endtask

  task automatic test_partial_strobe();
    logic [1:0] r; logic [31:0] d; int lat; bit ok;
    axi_write(32'h0000_0010, 32'h0000_5500, 4'b0010, r, lat, ok);
    axi_read(32'h0000_0010, d, r, lat, ok);
    n_total++;
    if (!ok || d !== 32'hDEAD_55EF || r !== 2'b00)
      $display("FAIL partial_strobe got=%h/%b exp=dead55ef/00", d, r);
    else n_pass++;
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r; logic [31:0] d; int lat; bit ok;
    bit got_w, got_aw, f, early, stable, hs;
    int n, nb;
    logic [1:0] rdy_after;
    got_w = 0; got_aw = 0; early = 0; stable = 1; nb = 0; rdy_after = 'x;
    bus.mem_axi_bready = 0;
    bus.mem_axi_wdata = 32'h1234_5678; bus.mem_axi_wstrb = 4'hF; bus.mem_axi_wvalid = 1;
    for (int t = 0; t < 20 && !got_w; t++) begin
      f = bus.mem_axi_wvalid && bus.mem_axi_wready;
      step();
      if (f) begin bus.mem_axi_wvalid = 0; got_w = 1; end
    end
    n_total++;
    if (!got_w || {bus.mem_axi_wready, bus.mem_axi_awready} !== 2'b01)
      $display("FAIL w_alone_accept got_w=%0b wready/awready=%b exp 1 and 01",
               got_w, {bus.mem_axi_wready, bus.mem_axi_awready});
    else n_pass++;
    repeat (3) begin
      if (bus.mem_axi_bvalid !== 1'b0) early = 1;
      step();
    end
    n_total++;
    if (early) $display("FAIL w_alone_no_commit bvalid seen=1 exp=0"); else n_pass++;
    bus.mem_axi_awaddr = 32'h0000_0020; bus.mem_axi_awvalid = 1;
    for (int t = 0; t < 20 && !got_aw; t++) begin
      f = bus.mem_axi_awvalid && bus.mem_axi_awready;
      step();
      if (f) begin bus.mem_axi_awvalid = 0; got_aw = 1; end
    end
    n = 0;
    while (n < 10 && bus.mem_axi_bvalid !== 1'b1) begin n++; step(); end
    n_total++;
    if (!got_aw || n != 1)
      $display("FAIL late_aw_bvalid got_aw=%0b wait=%0d exp 1 and 1", got_aw, n);
    else n_pass++;
    repeat (5) begin
      if (bus.mem_axi_bvalid !== 1'b1 || bus.mem_axi_bresp !== 2'b00) stable = 0;
      step();
    end
    n_total++;
    if (!stable) $display("FAIL bvalid_hold stable=0 exp=1"); else n_pass++;
    bus.mem_axi_bready = 1;
    repeat (4) begin
      hs = bus.mem_axi_bvalid && bus.mem_axi_bready;
      if (hs) nb++;
      step();
      if (hs) rdy_after = {bus.mem_axi_awready, bus.mem_axi_wready};
    end
    bus.mem_axi_bready = 0;
    n_total++;
    if (nb != 1) $display("FAIL single_b_handshake got=%0d exp=1", nb); else n_pass++;
    n_total++;
    if (rdy_after !== 2'b11) $display("FAIL ready_after_b got=%b exp=11", rdy_after); else n_pass++;
    axi_read(32'h0000_0020, d, r, lat, ok);
    n_total++;
    if (!ok || d !== 32'h1234_5678) $display("FAIL late_aw_readback got=%h exp=12345678", d);
    else n_pass++;
  endtask

  task automatic test_mmio();
    logic [1:0] r; logic [31:0] d; int lat; bit ok;
    ov_count = 0;
    axi_write(32'h1000_0000, 32'h0000_0041, 4'b0001, r, lat, ok);
    repeat (4) step();
    n_total++;
    if (!ok || r !== 2'b00 || ov_count != 1 || ov_last !== 8'h41)
      $display("FAIL console_pulse resp=%b pulses=%0d data=%h exp 00/1/41", r, ov_count, ov_last);
    else n_pass++;
    axi_write(32'h2000_0000, 32'd5, 4'b1111, r, lat, ok);
    n_total++;
    if (tests_passed !== 1'b0) $display("FAIL pass_wrong_value got=%b exp=0", tests_passed);
    else n_pass++;
    axi_write(32'h2000_0000, 32'd123456789, 4'b1111, r, lat, ok);
    n_total++;
    if (tests_passed !== 1'b1 || r !== 2'b00)
      $display("FAIL pass_set got=%b/%b exp=1/00", tests_passed, r);
    else n_pass++;
    axi_write(32'h2000_0000, 32'd0, 4'b1111, r, lat, ok);
    axi_read(32'h2000_0000, d, r, lat, ok);
    n_total++;
    if (tests_passed !== 1'b1 || d !== 32'h1 || r !== 2'b00)
      $display("FAIL pass_sticky flag=%b rdata=%h rresp=%b exp 1/00000001/00", tests_passed, d, r);
    else n_pass++;
    axi_read(32'h1000_0000, d, r, lat, ok);
    n_total++;
    if (!ok || d !== 32'h0 || r !== 2'b00) $display("FAIL console_read got=%h/%b exp=0/00", d, r);
    else n_pass++;
  endtask

  task automatic test_decerr();
    logic [1:0] r; logic [31:0] d; int lat; bit ok;
    axi_read(32'h0001_0000, d, r, lat, ok);
    n_total++;
    if (!ok || d !== 32'h0 || r !== 2'b11) $display("FAIL read_decerr got=%h/%b exp=0/11", d, r);
    else n_pass++;
    axi_write(32'h0000_FFFC, 32'hA5A5_5A5A, 4'b1111, r, lat, ok);
    axi_read(32'h0000_FFFC, d, r, lat, ok);
    n_total++;
    if (d !== 32'hA5A5_5A5A || r !== 2'b00) $display("FAIL last_word got=%h/%b exp=a5a55a5a/00", d, r);
    else n_pass++;
    axi_write(32'h0000_0000, 32'h1111_1111, 4'b1111, r, lat, ok);
    axi_write(32'h3000_0000, 32'hCAFE_F00D, 4'b1111, r, lat, ok);
    n_total++;
    if (!ok || r !== 2'b11) $display("FAIL write_decerr bresp=%b exp=11", r); else n_pass++;
    axi_read(32'h0000_0000, d, r, lat, ok);
    n_total++;
    if (d !== 32'h1111_1111) $display("FAIL decerr_no_side_effect got=%h exp=11111111", d);
    else n_pass++;
  endtask

  // AR handshake lands on the commit cycle of a write to the same word.
  task automatic test_collision();
    logic [1:0] r; logic [31:0] d; int lat; bit ok;
    axi_write(32'h0000_0040, 32'hAAAA_0000, 4'b1111, r, lat, ok);
    bus.mem_axi_awaddr = 32'h0000_0040; bus.mem_axi_awvalid = 1;
    bus.mem_axi_wdata = 32'h5555_FFFF; bus.mem_axi_wstrb = 4'hF; bus.mem_axi_wvalid = 1;
    n_total++;
    if ({bus.mem_axi_awready, bus.mem_axi_wready, bus.mem_axi_arready} !== 3'b111)
      $display("FAIL collision_idle_ready got=%b exp=111",
               {bus.mem_axi_awready, bus.mem_axi_wready, bus.mem_axi_arready});
    else n_pass++;
    step();
    bus.mem_axi_awvalid = 0; bus.mem_axi_wvalid = 0;
    bus.mem_axi_araddr = 32'h0000_0040; bus.mem_axi_arvalid = 1;
    step();
    bus.mem_axi_arvalid = 0;
    n_total++;
    if ({bus.mem_axi_rvalid, bus.mem_axi_bvalid} !== 2'b11 || bus.mem_axi_rdata !== 32'hAAAA_0000)
      $display("FAIL collision_old_data rvalid/bvalid=%b rdata=%h exp 11/aaaa0000",
               {bus.mem_axi_rvalid, bus.mem_axi_bvalid}, bus.mem_axi_rdata);
    else n_pass++;
    bus.mem_axi_rready = 1; bus.mem_axi_bready = 1;
    step();
    bus.mem_axi_rready = 0; bus.mem_axi_bready = 0;
    axi_read(32'h0000_0040, d, r, lat, ok);
    n_total++;
    if (d !== 32'h5555_FFFF) $display("FAIL collision_new_data got=%h exp=5555ffff", d);
    else n_pass++;
  endtask

  task automatic test_latency4_reset();
    bit f, ok, got, seen;
    int hs_t, lat;
    logic [31:0] d; logic [1:0] r;
    ok = 0; hs_t = -1; lat = -1; d = 'x; r = 'x; got = 0; seen = 0;
    bus4.mem_axi_araddr = 32'h2000_0000; bus4.mem_axi_arvalid = 1; bus4.mem_axi_rready = 1;
    for (int t = 0; t < 40 && !ok; t++) begin
      f = (hs_t < 0) && bus4.mem_axi_arvalid && bus4.mem_axi_arready;
      if (hs_t >= 0 && bus4.mem_axi_rvalid) begin
        ok = 1; lat = t - hs_t; d = bus4.mem_axi_rdata; r = bus4.mem_axi_rresp;
      end
      step();
      if (f) begin bus4.mem_axi_arvalid = 0; hs_t = t; end
    end
    bus4.mem_axi_rready = 0;
    n_total++;
    if (!ok || lat != 4) $display("FAIL lat4_latency ok=%0b lat=%0d exp 1/4", ok, lat); else n_pass++;
    n_total++;
    if (d !== 32'h0 || r !== 2'b00) $display("FAIL lat4_data got=%h/%b exp=0/00", d, r); else n_pass++;
    step();
    bus4.mem_axi_arvalid = 1;
    for (int t = 0; t < 20 && !got; t++) begin
      f = bus4.mem_axi_arvalid && bus4.mem_axi_arready;
      step();
      if (f) begin bus4.mem_axi_arvalid = 0; got = 1; end
    end
    step();
    rst4_n = 0;
    step();
    n_total++;
    if (!got || {bus4.mem_axi_rvalid, bus4.mem_axi_arready} !== 2'b00)
      $display("FAIL lat4_in_reset got_ar=%0b rvalid/arready=%b exp 1/00",
               got, {bus4.mem_axi_rvalid, bus4.mem_axi_arready});
    else n_pass++;
    step();
    rst4_n = 1;
    step();
    n_total++;
    if (bus4.mem_axi_arready !== 1'b1) $display("FAIL lat4_arready_after_reset got=%b exp=1",
                                                bus4.mem_axi_arready);
    else n_pass++;
    repeat (8) begin
      if (bus4.mem_axi_rvalid !== 1'b0) seen = 1;
      step();
    end
    n_total++;
    if (seen) $display("FAIL lat4_dropped_read rvalid seen=1 exp=0"); else n_pass++;
  endtask

  initial begin
    init_bus();
    test_reset();
    test_basic_rw();
    test_partial_strobe();
    test_w_before_aw();
    test_mmio();
    test_decerr();
    test_collision();
    test_latency4_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
